// File: rtl/mem_access_ctrl_pkg.sv
// Shared option codes, FSM states, default timeout and the misalignment rule for mem_access_ctrl.
package mem_access_ctrl_pkg;

  localparam int unsigned MAC_TIMEOUT_DEFAULT = 16;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LBU = 3'b001,
    LD_LH  = 3'b010,
    LD_LHU = 3'b011,
    LD_LW  = 3'b100
  } load_opt_e;

  typedef enum logic [1:0] {
    ST_SB     = 2'b00,
    ST_SH     = 2'b01,
    ST_SW     = 2'b10,
    ST_SW_ALT = 2'b11
  } store_opt_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_DONE   = 2'b10,
    S_ERR    = 2'b11
  } state_e;

  // Option code 11 on stores behaves as sw, so it falls into the word rule.
  function automatic logic is_misaligned(input logic       we,
                                         input logic [1:0] st_opt,
                                         input logic [2:0] ld_opt,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (we) begin
      case (store_opt_e'(st_opt))
        ST_SB:   mis = 1'b0;
        ST_SH:   mis = addr_lo[0];
        default: mis = |addr_lo;
      endcase
    end else begin
      case (ld_opt)
        LD_LH, LD_LHU: mis = addr_lo[0];
        LD_LW:         mis = |addr_lo;
        default:       mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_store_align.sv
// Store lane steering: byte enables and lane-replicated write data from the low address bits.
module store_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_store_option,
  input  logic [31:0] i_din,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata
);

  always_comb begin
    o_mem_be    = '0;
    o_mem_wdata = '0;
    case (store_opt_e'(i_store_option))
      ST_SB: begin
        o_mem_be    = 4'b0001 << i_addr_lo;
        o_mem_wdata = {4{i_din[7:0]}};
      end
      ST_SH: begin
        o_mem_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_mem_wdata = {2{i_din[15:0]}};
      end
      default: begin
        o_mem_be    = 4'b1111;
        o_mem_wdata = i_din;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-to-memory access controller with wait-state timeout; all outputs registered.
// Misaligned-access trapping is enabled by defining MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = MAC_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] Addr,
  input  logic [31:0] Din,
  input  logic [1:0]  store_option,
  input  logic [2:0]  load_option,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] Dout,
  output logic [31:0] Addr_q,
  output logic [2:0]  load_option_q,
  output logic        busy,
  output logic        done,
  output logic        bus_err,
  output logic        misalign
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_we_q;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_dout;
  logic [31:0]       r_addr_q;
  logic [2:0]        r_ld_opt_q;
  logic              r_busy;
  logic              r_done;
  logic              r_bus_err;
  logic              r_misalign;

  logic [3:0]        w_st_be;
  logic [31:0]       w_st_wdata;
  logic              w_misalign;

  // Steering is computed from the live request inputs and captured on acceptance,
  // so the lane outputs are already registered when ACCESS begins.
  store_align u_store_align (
    .i_addr_lo      (Addr[1:0]),
    .i_store_option (store_option),
    .i_din          (Din),
    .o_mem_be       (w_st_be),
    .o_mem_wdata    (w_st_wdata)
  );

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(we, store_option, load_option, Addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_we_q      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_dout      <= '0;
      r_addr_q    <= '0;
      r_ld_opt_q  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bus_err   <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_bus_err  <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_addr_q   <= Addr;
            r_ld_opt_q <= load_option;
            r_we_q     <= we;
            r_busy     <= 1'b1;
            if (w_misalign) begin
              r_state    <= S_ERR;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
            end else begin
              r_state     <= S_ACCESS;
              r_wait_cnt  <= '0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= we;
              r_mem_addr  <= {Addr[31:2], 2'b00};
              r_mem_be    <= we ? w_st_be : 4'b1111;
              r_mem_wdata <= we ? w_st_wdata : '0;
            end
          end
        end
        S_ACCESS: begin
          // Completion wins over timeout when both land in the same cycle.
          if (mem_ready || (r_wait_cnt == TO_LAST)) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b1;
            if (mem_ready) begin
              r_state <= S_DONE;
              if (!r_we_q) r_dout <= mem_rdata;
            end else begin
              r_state   <= S_ERR;
              r_bus_err <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_DONE, S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_be        = r_mem_be;
  assign mem_wdata     = r_mem_wdata;
  assign Dout          = r_dout;
  assign Addr_q        = r_addr_q;
  assign load_option_q = r_ld_opt_q;
  assign busy          = r_busy;
  assign done          = r_done;
  assign bus_err       = r_bus_err;
  assign misalign      = r_misalign;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16; it is the maximum number of ACCESS cycles to wait for mem_ready before aborting.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 1 bit: CPU access request, sampled only in IDLE.
REQ-005 The block SHALL have port we, input, 1 bit: 1 = store, 0 = load.
REQ-006 The block SHALL have port Addr, input, 32 bits: byte address.
REQ-007 The block SHALL have port Din, input, 32 bits: store data, with the payload in the low bits.
REQ-008 The block SHALL have port store_option, input, 2 bits: 00 = sb, 01 = sh, 10 = sw.
REQ-009 The block SHALL have port load_option, input, 3 bits: 000 = lb, 001 = lbu, 010 = lh, 011 = lhu, 100 = lw.
REQ-010 The block SHALL have port mem_req, output, 1 bit: memory request.
REQ-011 The block SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-012 The block SHALL have port mem_addr, output, 32 bits: word-aligned address.
REQ-013 The block SHALL have port mem_be, output, 4 bits: byte-lane enables.
REQ-014 The block SHALL have port mem_wdata, output, 32 bits: lane-replicated store data.
REQ-015 The block SHALL have port mem_ready, input, 1 bit: memory completion.
REQ-016 The block SHALL have port mem_rdata, input, 32 bits: raw read word.
REQ-017 The block SHALL have port Dout, output, 32 bits: registered raw read word, fed to the load extender.
REQ-018 The block SHALL have port Addr_q, output, 32 bits: latched byte address for the load extender.
REQ-019 The block SHALL have port load_option_q, output, 3 bits: latched load option for the load extender.
REQ-020 The block SHALL have ports busy, done, bus_err and misalign, each output, 1 bit: status signals.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS, DONE and ERR.
REQ-022 In IDLE with req=1, the block SHALL latch Addr, Din, we, store_option and load_option, then go to ERR if the access is misaligned (REQ-031) and to ACCESS otherwise.
REQ-023 The block SHALL ignore req in every state except IDLE; busy SHALL be 1 in every state except IDLE.
REQ-024 In ACCESS, mem_req SHALL be 1, mem_addr SHALL be {Addr_q[31:2],2'b00}, and mem_we SHALL equal the latched we.
REQ-025 In ACCESS, the wait counter SHALL start at 0 on entry and increment each cycle without mem_ready.
REQ-026 In ACCESS with mem_ready=1 and a load, Dout SHALL capture mem_rdata and the FSM SHALL go to DONE.
REQ-027 In ACCESS with mem_ready=1 and a store, Dout SHALL be unchanged and the FSM SHALL go to DONE.
REQ-028 In ACCESS, if the counter equals TIMEOUT-1 and mem_ready=0, the FSM SHALL go to ERR with bus_err set; mem_ready in that same cycle SHALL take priority over timeout.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE; minimum latency from req to done SHALL be 2 cycles.
REQ-030 ERR SHALL last one cycle with done=1 and exactly one of bus_err or misalign set, then return to IDLE; no mem_req SHALL be issued for a misaligned access.
REQ-031 An access SHALL be misaligned when it is lh, lhu or sh with Addr[0]=1, or lw or sw with Addr[1:0]!=0.
REQ-032 Loads SHALL drive mem_be=4'b1111.
REQ-033 sb SHALL drive mem_be = 4'b0001 << Addr[1:0] and mem_wdata = {4{Din[7:0]}}.
REQ-034 sh SHALL drive mem_be = 4'b1100 if Addr[1]=1 and 4'b0011 otherwise, with mem_wdata = {2{Din[15:0]}}.
REQ-035 sw SHALL drive mem_be=4'b1111 and mem_wdata=Din.
REQ-036 Store option 11 SHALL be treated as sw.
REQ-037 Dout, Addr_q and load_option_q SHALL hold their values until the next accepted request or completed load.
REQ-038 mem_we, mem_be and mem_wdata SHALL be 0 outside ACCESS.

Reset
REQ-039 On reset=1 at a clock edge, the FSM SHALL enter IDLE.
REQ-040 On reset, the wait counter and all outputs (Dout, Addr_q, load_option_q, mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy, done, bus_err, misalign) SHALL be 0.
REQ-041 Reset SHALL abort any in-flight access immediately, with mem_req=0 from the next cycle.

Configuration
REQ-042 With macro MEM_ACCESS_MISALIGN_TRAP_EN defined, the misalignment check of REQ-031 SHALL be active.
REQ-043 Without MEM_ACCESS_MISALIGN_TRAP_EN, misalign SHALL be tied to 0, the ERR state SHALL be entered only on timeout, and unaligned half/word accesses SHALL proceed using Addr[1] and the word address only.

Structure
REQ-044 A shared package SHALL hold the load option codes, the store option codes, the FSM state encoding and the TIMEOUT default.
REQ-045 A sub-module store_align (Addr[1:0], store_option, Din -> mem_be, mem_wdata) SHALL be instantiated once.

Verification
REQ-046 Bench SHALL check: lw, Addr=0x00000104, mem_ready after 3 cycles with rdata=0xDEADBEEF -> mem_addr=0x00000104, mem_be=1111, Dout=0xDEADBEEF, done 5 cycles after req.
REQ-047 Bench SHALL check: sb, Addr=0x00000023, Din=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x00000020, Dout unchanged.
REQ-048 Bench SHALL check: sh, Addr=0x00000042, Din=0x00001234 -> mem_be=1100, mem_wdata=0x12341234.
REQ-049 Bench SHALL check: lh, Addr=0x00000041, with the macro defined -> no mem_req, done=1 and misalign=1 in the cycle after req; without the macro -> a normal access with mem_be=1111.
REQ-050 Bench SHALL check: TIMEOUT=4, mem_ready held at 0 -> exactly 4 mem_req cycles, then bus_err=1 and done=1, then IDLE.
REQ-051 Bench SHALL check: reset asserted during the 2nd ACCESS cycle -> next cycle IDLE with all outputs 0; a req issued in the following cycle is accepted normally.
